lsu_wr_sched: RTL and testbench
===============================

# lsu_wr_sched

Store scheduler between the LSU write port and the two write-buffered targets in the LSU address map: the output-peripheral buffer (0x7000–0x70FF) and the SDRAM write buffer (0x2000–0x3FFF). Accepts LSU stores into a small in-order queue, decodes the target region, and drains each entry either as a single-cycle output-buffer write or as a req/ack transaction to the SDRAM buffer. Stalls the LSU when the queue is full, so SDRAM back-pressure never loses a store.

## Interface
- DEPTH, 4, store queue entries (power of two, ≥2)
- DATA_W, 32, store data width
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset; synchronous, active-low
- i_lsu_addr  in  32  store address
- i_lsu_wdata  in  DATA_W  store data
- i_lsu_bmask  in  DATA_W/8  byte-enable mask
- i_lsu_wren  in  1  store request
- o_lsu_stall  out  1  queue full; store this cycle not accepted
- o_out_wren  out  1  output-buffer write strobe (one cycle per entry)
- o_out_addr  out  8  output-buffer offset (addr[7:0])
- o_out_wdata  out  DATA_W  output-buffer data
- o_out_bmask  out  DATA_W/8  output-buffer byte mask
- o_sdr_req  out  1  SDRAM-buffer write request
- i_sdr_ack  in  1  SDRAM-buffer accepts current request
- o_sdr_addr  out  13  SDRAM-buffer offset (addr[12:0])
- o_sdr_wdata  out  DATA_W  SDRAM-buffer data
- o_sdr_bmask  out  DATA_W/8  SDRAM-buffer byte mask
- o_busy  out  1  queue non-empty or transaction in flight

## Operation
- Region decode on i_lsu_addr[15:0] (bits [31:16] ignored): OUT if addr[15:8]==8'h70; SDR if addr[15:13]==3'b001; otherwise NONE.
- Accept: i_lsu_wren & ~o_lsu_stall at an edge. OUT/SDR stores are pushed with a 1-bit target tag; NONE stores are accepted and discarded (never stall, never enqueued).
- o_lsu_stall = (count == DEPTH), driven from registered count. Stalled stores are ignored; LSU holds them.
- Strict in-order drain; an SDR entry at head blocks later OUT entries.
- FSM states: IDLE, OUT_WR, SDR_REQ.
  - IDLE: queue empty → stay. Head OUT → load out regs, pop, go OUT_WR. Head SDR → load sdr regs, go SDR_REQ.
  - OUT_WR: o_out_wren=1 for this cycle. Next head handled exactly as from IDLE (back-to-back OUT at 1/cycle); empty → IDLE.
  - SDR_REQ: o_sdr_req=1, o_sdr_addr/wdata/bmask stable. Edge with i_sdr_ack=1 → pop; next head handled as from IDLE (SDR head keeps req high with new payload). i_sdr_ack while req low is ignored.
- Push and pop on the same edge: count unchanged. Pointers wrap modulo DEPTH.
- o_busy = (count != 0) | (state != IDLE).
- Reset (mid-operation included): queue emptied, pointers/count = 0, state IDLE, in-flight SDR request dropped (req falls next cycle; SDRAM side must treat a dropped req as aborted).

## Timing
- Reset values: o_lsu_stall=0, o_out_wren=0, o_out_addr=0, o_out_wdata=0, o_out_bmask=0, o_sdr_req=0, o_sdr_addr=0, o_sdr_wdata=0, o_sdr_bmask=0, o_busy=0.
- All outputs registered (except bypass term below).
- Empty queue, store accepted at edge N: OUT → o_out_wren high during cycle after edge N+1; SDR → o_sdr_req high after edge N+1.
- SDR entry retires at the first edge with req & ack; minimum 1 cycle req-high.
- Full queue with concurrent pop: stall remains asserted that cycle; no push.

## Configuration
- LSU_WRQ_BYPASS_EN defined: when queue empty and state IDLE, an accepted OUT store drives o_out_wren/addr/wdata/bmask combinationally in the same cycle and is not enqueued (zero latency). SDR stores never bypass.
- Undefined: no bypass; all outputs purely registered; latency as in Timing.

## Test plan
- Reset, then store 0x7004 data 0xA5A5A5A5 mask 0xF → single o_out_wren pulse, o_out_addr=0x04, data/mask match, latency 2 edges (0 with bypass).
- Store to 0x2010, i_sdr_ack held low 5 cycles then high → o_sdr_req high 6 cycles, payload stable, entry retires at ack edge, o_busy falls next cycle.
- Ack low, issue 5 SDR stores back-to-back → first 4 accepted (one in SDR_REQ counts as queued), o_lsu_stall high on 5th until first ack; all 5 delivered in order.
- Interleave SDR 0x2000, OUT 0x7000, OUT 0x70FF with ack delayed 3 cycles → OUT writes only after SDR retires, then two consecutive o_out_wren cycles.
- Stores to 0x4000, 0x7100, 0xF000 → accepted, no stall, no output activity, o_busy stays 0.
- Assert i_rst_n=0 one cycle while o_sdr_req high with 3 entries queued → next cycle all outputs at reset values, queue empty, later ack ignored.

Source files
------------

// File: rtl/lsu_wr_sched.sv
// -----------------------------------------------------------------------------
// lsu_wr_sched
// Store scheduler between the LSU write port and the two write-buffered
// targets: the output-peripheral buffer (0x7000-0x70FF) and the SDRAM write
// buffer (0x2000-0x3FFF). Stores to either region are queued in order and
// drained one at a time; stores elsewhere are accepted and dropped.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_lsu_addr/wdata/bmask    LSU store payload
//   i_lsu_wren                LSU store request
//   o_lsu_stall               queue full, store not taken this cycle
//   o_out_wren/addr/wdata/bmask  single-cycle output-buffer write
//   o_sdr_req/addr/wdata/bmask   SDRAM-buffer request, held until i_sdr_ack
//   i_sdr_ack                 SDRAM buffer takes the current request
//   o_busy                    queue non-empty or transaction in flight
//
// Build option: LSU_WRQ_BYPASS_EN -- an OUT store arriving while the
// scheduler is completely idle is written to the output buffer in the same
// cycle instead of being queued. Default build has no bypass.
// -----------------------------------------------------------------------------
module lsu_wr_sched #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [31:0]           i_lsu_addr,
    input  logic [DATA_W-1:0]     i_lsu_wdata,
    input  logic [DATA_W/8-1:0]   i_lsu_bmask,
    input  logic                  i_lsu_wren,
    output logic                  o_lsu_stall,
    output logic                  o_out_wren,
    output logic [7:0]            o_out_addr,
    output logic [DATA_W-1:0]     o_out_wdata,
    output logic [DATA_W/8-1:0]   o_out_bmask,
    output logic                  o_sdr_req,
    input  logic                  i_sdr_ack,
    output logic [12:0]           o_sdr_addr,
    output logic [DATA_W-1:0]     o_sdr_wdata,
    output logic [DATA_W/8-1:0]   o_sdr_bmask,
    output logic                  o_busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OUT_WR  = 2'd1,
        ST_SDR_REQ = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // Queue storage; r_q_sdr is the target tag (1 = SDRAM, 0 = output buffer)
    logic                r_q_sdr  [DEPTH];
    logic [12:0]         r_q_addr [DEPTH];
    logic [DATA_W-1:0]   r_q_data [DEPTH];
    logic [MASK_W-1:0]   r_q_mask [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                r_stall;
    logic                r_busy;
    logic                r_out_wren;
    logic [7:0]          r_out_addr;
    logic [DATA_W-1:0]   r_out_wdata;
    logic [MASK_W-1:0]   r_out_bmask;
    logic                r_sdr_req;
    logic [12:0]         r_sdr_addr;
    logic [DATA_W-1:0]   r_sdr_wdata;
    logic [MASK_W-1:0]   r_sdr_bmask;

    logic                w_out_wren_nxt;
    logic [7:0]          w_out_addr_nxt;
    logic [DATA_W-1:0]   w_out_wdata_nxt;
    logic [MASK_W-1:0]   w_out_bmask_nxt;
    logic                w_sdr_req_nxt;
    logic [12:0]         w_sdr_addr_nxt;
    logic [DATA_W-1:0]   w_sdr_wdata_nxt;
    logic [MASK_W-1:0]   w_sdr_bmask_nxt;

    logic                w_is_out;
    logic                w_is_sdr;
    logic                w_bypass;
    logic                w_push;
    logic                w_retire_sdr;
    logic                w_reselect;
    logic [PTR_W-1:0]    w_sel_idx;
    logic                w_sel_vld;
    logic                w_sel_out;
    logic                w_sel_sdr;
    logic [CNT_W-1:0]    w_pop_cnt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_unused_addr;

    assign w_unused_addr = ^i_lsu_addr[31:16];

    assign w_is_out = (i_lsu_addr[15:8] == 8'h70);
    assign w_is_sdr = (i_lsu_addr[15:13] == 3'b001);

`ifdef LSU_WRQ_BYPASS_EN
    assign w_bypass    = i_lsu_wren & ~r_stall & w_is_out &
                         (r_count == {CNT_W{1'b0}}) & (r_state == ST_IDLE);
    assign o_out_wren  = r_out_wren | w_bypass;
    assign o_out_addr  = w_bypass ? i_lsu_addr[7:0] : r_out_addr;
    assign o_out_wdata = w_bypass ? i_lsu_wdata     : r_out_wdata;
    assign o_out_bmask = w_bypass ? i_lsu_bmask     : r_out_bmask;
`else
    assign w_bypass    = 1'b0;
    assign o_out_wren  = r_out_wren;
    assign o_out_addr  = r_out_addr;
    assign o_out_wdata = r_out_wdata;
    assign o_out_bmask = r_out_bmask;
`endif

    assign o_lsu_stall = r_stall;
    assign o_sdr_req   = r_sdr_req;
    assign o_sdr_addr  = r_sdr_addr;
    assign o_sdr_wdata = r_sdr_wdata;
    assign o_sdr_bmask = r_sdr_bmask;
    assign o_busy      = r_busy;

    assign w_push = i_lsu_wren & ~r_stall & (w_is_out | w_is_sdr) & ~w_bypass;

    // An acked SDR entry is popped on the same edge, so the following entry
    // (rd_ptr+1) is already eligible to be dispatched; this is what keeps
    // req high across back-to-back SDR entries and can pop two entries at once.
    assign w_retire_sdr = (r_state == ST_SDR_REQ) & i_sdr_ack;
    assign w_reselect   = (r_state == ST_IDLE) | (r_state == ST_OUT_WR) | w_retire_sdr;
    assign w_sel_idx    = w_retire_sdr ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
    assign w_sel_vld    = w_reselect &
                          (w_retire_sdr ? (r_count > CNT_W'(1)) : (r_count != {CNT_W{1'b0}}));
    assign w_sel_out    = w_sel_vld & ~r_q_sdr[w_sel_idx];
    assign w_sel_sdr    = w_sel_vld &  r_q_sdr[w_sel_idx];

    // OUT entries leave the queue when dispatched; SDR entries only on ack
    assign w_pop_cnt   = CNT_W'(w_retire_sdr) + CNT_W'(w_sel_out);
    assign w_count_nxt = r_count + CNT_W'(w_push) - w_pop_cnt;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_OUT_WR: begin
                if (w_sel_out) begin
                    w_state_nxt = ST_OUT_WR;
                end else if (w_sel_sdr) begin
                    w_state_nxt = ST_SDR_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SDR_REQ: begin
                if (!i_sdr_ack) begin
                    w_state_nxt = ST_SDR_REQ;
                end else if (w_sel_out) begin
                    w_state_nxt = ST_OUT_WR;
                end else if (w_sel_sdr) begin
                    w_state_nxt = ST_SDR_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: next values of the registered target-side outputs
    always_comb begin
        w_out_wren_nxt = (w_state_nxt == ST_OUT_WR);
        w_sdr_req_nxt  = (w_state_nxt == ST_SDR_REQ);
        if (w_sel_out) begin
            w_out_addr_nxt  = r_q_addr[w_sel_idx][7:0];
            w_out_wdata_nxt = r_q_data[w_sel_idx];
            w_out_bmask_nxt = r_q_mask[w_sel_idx];
        end else begin
            w_out_addr_nxt  = r_out_addr;
            w_out_wdata_nxt = r_out_wdata;
            w_out_bmask_nxt = r_out_bmask;
        end
        if (w_sel_sdr) begin
            w_sdr_addr_nxt  = r_q_addr[w_sel_idx];
            w_sdr_wdata_nxt = r_q_data[w_sel_idx];
            w_sdr_bmask_nxt = r_q_mask[w_sel_idx];
        end else begin
            w_sdr_addr_nxt  = r_sdr_addr;
            w_sdr_wdata_nxt = r_sdr_wdata;
            w_sdr_bmask_nxt = r_sdr_bmask;
        end
    end

    // Output, status, pointer and count registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_wren  <= 1'b0;
            r_out_addr  <= 8'h00;
            r_out_wdata <= {DATA_W{1'b0}};
            r_out_bmask <= {MASK_W{1'b0}};
            r_sdr_req   <= 1'b0;
            r_sdr_addr  <= 13'h0000;
            r_sdr_wdata <= {DATA_W{1'b0}};
            r_sdr_bmask <= {MASK_W{1'b0}};
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_stall     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_wren  <= w_out_wren_nxt;
            r_out_addr  <= w_out_addr_nxt;
            r_out_wdata <= w_out_wdata_nxt;
            r_out_bmask <= w_out_bmask_nxt;
            r_sdr_req   <= w_sdr_req_nxt;
            r_sdr_addr  <= w_sdr_addr_nxt;
            r_sdr_wdata <= w_sdr_wdata_nxt;
            r_sdr_bmask <= w_sdr_bmask_nxt;
            r_wr_ptr    <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr    <= r_rd_ptr + PTR_W'(w_pop_cnt);
            r_count     <= w_count_nxt;
            r_stall     <= (w_count_nxt == CNT_W'(DEPTH));
            r_busy      <= (w_count_nxt != {CNT_W{1'b0}}) | (w_state_nxt != ST_IDLE);
        end
    end

    // Queue storage write
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_sdr[i]  <= 1'b0;
                r_q_addr[i] <= 13'h0000;
                r_q_data[i] <= {DATA_W{1'b0}};
                r_q_mask[i] <= {MASK_W{1'b0}};
            end
        end else if (w_push) begin
            r_q_sdr[r_wr_ptr]  <= w_is_sdr;
            r_q_addr[r_wr_ptr] <= i_lsu_addr[12:0];
            r_q_data[r_wr_ptr] <= i_lsu_wdata;
            r_q_mask[r_wr_ptr] <= i_lsu_bmask;
        end else begin
            r_q_sdr[r_wr_ptr]  <= r_q_sdr[r_wr_ptr];
        end
    end

endmodule

// File: tb/tb_lsu_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_lsu_wr_sched
// Scoreboard bench for lsu_wr_sched (default build, no bypass). Every accepted
// store to a buffered region is pushed as an expected write; a monitor pops
// and compares whenever the DUT writes the output buffer or retires an SDRAM
// request. Directed scenarios check latency, stall, ordering, dropped regions
// and reset; a randomized run with random ack finishes the test.
// -----------------------------------------------------------------------------
module tb_lsu_wr_sched;

    logic         clk;
    logic         i_rst_n;
    logic [31:0]  i_lsu_addr;
    logic [31:0]  i_lsu_wdata;
    logic [3:0]   i_lsu_bmask;
    logic         i_lsu_wren;
    logic         o_lsu_stall;
    logic         o_out_wren;
    logic [7:0]   o_out_addr;
    logic [31:0]  o_out_wdata;
    logic [3:0]   o_out_bmask;
    logic         o_sdr_req;
    logic         i_sdr_ack;
    logic [12:0]  o_sdr_addr;
    logic [31:0]  o_sdr_wdata;
    logic [3:0]   o_sdr_bmask;
    logic         o_busy;

    typedef struct {
        bit          sdr;
        logic [12:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } rec_t;

    rec_t         exp_q[$];
    rec_t         mon_e;
    int           errors = 0;
    int           checks = 0;
    int           out_cnt = 0;
    int           sdr_cnt = 0;
    bit           ack_rand = 1'b0;
    bit           ack_dir  = 1'b0;
    bit           req_seen = 1'b0;
    logic [48:0]  req_cap;

    lsu_wr_sched #(.DEPTH(4), .DATA_W(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_lsu_addr  (i_lsu_addr),
        .i_lsu_wdata (i_lsu_wdata),
        .i_lsu_bmask (i_lsu_bmask),
        .i_lsu_wren  (i_lsu_wren),
        .o_lsu_stall (o_lsu_stall),
        .o_out_wren  (o_out_wren),
        .o_out_addr  (o_out_addr),
        .o_out_wdata (o_out_wdata),
        .o_out_bmask (o_out_bmask),
        .o_sdr_req   (o_sdr_req),
        .i_sdr_ack   (i_sdr_ack),
        .o_sdr_addr  (o_sdr_addr),
        .o_sdr_wdata (o_sdr_wdata),
        .o_sdr_bmask (o_sdr_bmask),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode of the LSU address map
    function automatic int region(input logic [31:0] a);
        if (a[15:8] == 8'h70)       return 1;
        else if (a[15:13] == 3'b001) return 2;
        else                         return 0;
    endfunction

    // Present a store and hold it until it is taken (LSU behaviour under stall)
    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, output int waited);
        logic st;
        bit   taken;
        rec_t r;
        waited = 0;
        taken  = 1'b0;
        i_lsu_addr  = a;
        i_lsu_wdata = d;
        i_lsu_bmask = m;
        i_lsu_wren  = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            st = o_lsu_stall;
            @(posedge clk);
            if (!st) begin
                taken = 1'b1;
                break;
            end
            waited++;
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL store_timeout: addr %0h never accepted", a);
        end else if (region(a) != 0) begin
            r.sdr  = (region(a) == 2);
            r.addr = a[12:0];
            r.data = d;
            r.mask = m;
            exp_q.push_back(r);
        end
        #1;
        i_lsu_wren = 1'b0;
    endtask

    // Wait (bounded) until the DUT is idle and every expected write was seen
    task automatic wait_idle(input string name);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!o_busy && exp_q.size() == 0) break;
        end
        chk({name, "_drain"}, 128'(exp_q.size()), 128'(0));
        chk({name, "_busy"}, 128'(o_busy), 128'(1'b0));
    endtask

    // SDRAM-side ack driver
    initial begin
        i_sdr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_sdr_ack = ack_rand ? ($urandom_range(0, 2) == 0) : ack_dir;
        end
    end

    // Monitor: pops and compares on every output-buffer write or SDR retire
    initial begin
        forever begin
            @(negedge clk);
            if (!i_rst_n) begin
                req_seen = 1'b0;
            end else begin
                if (o_out_wren) begin
                    out_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected: addr %0h with nothing expected", o_out_addr);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("out_write", 128'({1'b0, o_out_addr, o_out_wdata, o_out_bmask}),
                            128'({mon_e.sdr, mon_e.addr[7:0], mon_e.data, mon_e.mask}));
                    end
                end
                if (o_sdr_req) begin
                    if (!req_seen) begin
                        req_cap  = {o_sdr_addr, o_sdr_wdata, o_sdr_bmask};
                        req_seen = 1'b1;
                    end else begin
                        chk("sdr_stable", 128'({o_sdr_addr, o_sdr_wdata, o_sdr_bmask}), 128'(req_cap));
                    end
                    if (i_sdr_ack) begin
                        sdr_cnt++;
                        req_seen = 1'b0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL sdr_unexpected: addr %0h with nothing expected", o_sdr_addr);
                        end else begin
                            mon_e = exp_q.pop_front();
                            chk("sdr_write", 128'({1'b1, o_sdr_addr, o_sdr_wdata, o_sdr_bmask}),
                                128'({mon_e.sdr, mon_e.addr, mon_e.data, mon_e.mask}));
                        end
                    end
                end else begin
                    req_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int w5;
        int base;
        logic [31:0] a;
        logic [15:0] lo;

        i_rst_n     = 1'b0;
        i_lsu_addr  = 32'h0;
        i_lsu_wdata = 32'h0;
        i_lsu_bmask = 4'h0;
        i_lsu_wren  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out", 128'({o_lsu_stall, o_out_wren, o_out_addr, o_out_wdata, o_out_bmask, o_busy}), 128'(0));
        chk("rst_sdr", 128'({o_sdr_req, o_sdr_addr, o_sdr_wdata, o_sdr_bmask}), 128'(0));

        // Single OUT store: latency 2 edges, one pulse
        @(posedge clk);
        #1;
        store(32'h0000_7004, 32'hA5A5_A5A5, 4'hF, w);
        chk("t1_accept", 128'(w), 128'(0));
        @(negedge clk);
        chk("t1_wren_n", 128'({o_out_wren, o_busy}), 128'(2'b01));
        @(negedge clk);
        chk("t1_wren_n1", 128'({o_out_wren, o_out_addr}), 128'({1'b1, 8'h04}));
        @(negedge clk);
        chk("t1_pulse_end", 128'({o_out_wren, o_busy}), 128'(2'b00));
        chk("t1_out_cnt", 128'(out_cnt), 128'(1));

        // SDR store, ack held off 5 cycles: req high 6 cycles
        ack_dir = 1'b0;
        base = sdr_cnt;
        @(posedge clk);
        #1;
        store(32'h0000_2010, 32'h1234_5678, 4'h3, w);
        @(negedge clk);
        chk("t2_req_lat", 128'(o_sdr_req), 128'(1'b0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_req_high", 128'(o_sdr_req), 128'(1'b1));
            if (i == 4) ack_dir = 1'b1;
        end
        ack_dir = 1'b0;
        @(negedge clk);
        chk("t2_retired", 128'({o_sdr_req, o_busy}), 128'(2'b00));
        chk("t2_sdr_cnt", 128'(sdr_cnt - base), 128'(1));

        // Queue full with ack low: 5th store stalls until first ack
        @(posedge clk);
        #1;
        base = sdr_cnt;
        for (int i = 0; i < 4; i++) begin
            store(32'hABCD_2000 + 32'(i * 4), $urandom, 4'(i + 1), w);
            chk("t3_accept", 128'(w), 128'(0));
        end
        fork
            store(32'h0000_3FFC, 32'hDEAD_BEEF, 4'h8, w5);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t3_stall", 128'(o_lsu_stall), 128'(1'b1));
                end
                ack_dir = 1'b1;
            end
        join
        chk("t3_wait", 128'(w5), 128'(4));
        wait_idle("t3");
        chk("t3_sdr_cnt", 128'(sdr_cnt - base), 128'(5));
        ack_dir = 1'b0;

        // SDR then two OUT: OUT only after SDR retires, then back-to-back
        @(posedge clk);
        #1;
        base = out_cnt;
        store(32'h0000_2000, 32'h0000_0001, 4'h1, w);
        store(32'h0000_7000, 32'h0000_0002, 4'h2, w);
        store(32'h0000_70FF, 32'h0000_0003, 4'h4, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold", 128'({o_sdr_req, o_out_wren}), 128'(2'b10));
        end
        ack_dir = 1'b1;
        @(negedge clk);
        chk("t4_ack", 128'({o_sdr_req, i_sdr_ack}), 128'(2'b11));
        ack_dir = 1'b0;
        @(negedge clk);
        chk("t4_out0", 128'({o_sdr_req, o_out_wren, o_out_addr}), 128'({2'b01, 8'h00}));
        @(negedge clk);
        chk("t4_out1", 128'({o_out_wren, o_out_addr}), 128'({1'b1, 8'hFF}));
        @(negedge clk);
        chk("t4_done", 128'({o_out_wren, o_busy}), 128'(2'b00));
        chk("t4_out_cnt", 128'(out_cnt - base), 128'(2));

        // Stores outside both regions are dropped
        @(posedge clk);
        #1;
        store(32'h0000_4000, 32'h1111_1111, 4'hF, w);
        chk("t5_acc0", 128'(w), 128'(0));
        store(32'h0000_7100, 32'h2222_2222, 4'hF, w);
        chk("t5_acc1", 128'(w), 128'(0));
        store(32'h0000_F000, 32'h3333_3333, 4'hF, w);
        chk("t5_acc2", 128'(w), 128'(0));
        repeat (4) begin
            @(negedge clk);
            chk("t5_quiet", 128'({o_busy, o_out_wren, o_sdr_req, o_lsu_stall}), 128'(0));
        end

        // Reset with a request in flight and entries queued
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            store(32'h0000_2100 + 32'(i * 8), $urandom, 4'hF, w);
        end
        @(negedge clk);
        chk("t6_req_before", 128'({o_sdr_req, o_lsu_stall, o_busy}), 128'(3'b111));
        @(posedge clk);
        #1;
        i_rst_n = 1'b0;
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t6_rst_out", 128'({o_lsu_stall, o_out_wren, o_out_addr, o_out_wdata, o_out_bmask, o_busy}), 128'(0));
        chk("t6_rst_sdr", 128'({o_sdr_req, o_sdr_addr, o_sdr_wdata, o_sdr_bmask}), 128'(0));
        ack_dir = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_ack_ignored", 128'({o_sdr_req, o_out_wren, o_busy}), 128'(0));
        end
        ack_dir = 1'b0;

        // Randomized mix with random ack
        ack_rand = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 150; n++) begin
            lo = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       a = {16'($urandom), 8'h70, lo[7:0]};
                1:       a = {16'($urandom), 3'b001, lo[12:0]};
                default: a = {16'($urandom), lo | 16'h8000};
            endcase
            store(a, $urandom, 4'($urandom), w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle("rand");
        ack_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
